// File: rtl/rv_uart_loader_if.sv
// rv_uart_loader_if: dpram port-B write bundle driven by the serial loader.
// m_adr word-aligned byte address, m_dw lane-replicated data, m_we byte enables.
interface rv_uart_loader_if;
  logic [31:0] m_adr;
  logic [31:0] m_dw;
  logic [3:0]  m_we;

  modport master (output m_adr, m_dw, m_we);
  modport slave  (input  m_adr, m_dw, m_we);
endinterface

// File: rtl/rv_uart_loader.sv
// rv_uart_loader: break-triggered 8N1 loader, A5 + adr + len header, image to dpram B.
// Ports: clk, xreset, rxd in; core_xreset, busy, err out; m = port-B write bundle.
module rv_uart_loader #(
  parameter int unsigned CLK_HZ     = 60000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned ADDR_BITS  = 17,
  parameter int unsigned BREAK_BITS = 20
) (
  input  logic clk,
  input  logic xreset,
  input  logic rxd,
  output logic core_xreset,
  output logic busy,
  output logic err,
  rv_uart_loader_if.master m
);

  localparam int unsigned DIV   = CLK_HZ / BAUD;
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned BRK_N = BREAK_BITS * DIV;
  localparam int unsigned CW    = $clog2(DIV);
  localparam int unsigned BW    = $clog2(BRK_N + 1);

  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [BW-1:0] BRK_TOP = BW'(BRK_N);
  localparam logic [BW-1:0] BRK_M1  = BW'(BRK_N - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_BRK  = 3'd1;
  localparam logic [2:0] ST_SYNC = 3'd2;
  localparam logic [2:0] ST_ADR  = 3'd3;
  localparam logic [2:0] ST_LEN  = 3'd4;
  localparam logic [2:0] ST_DATA = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd6;
  localparam logic [2:0] ST_ERR  = 3'd7;

  logic          rx_s1;
  logic          rx_s;
  logic          rx_q;
  logic [BW-1:0] brk_cnt;
  logic          brk_hit;

  logic          rx_on;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          byte_valid;
  logic          frame_err;

  logic [2:0]    state;
  logic [1:0]    hdr_idx;
  logic [31:0]   addr;
  logic [31:0]   len;
  logic [31:0]   len_nxt;
  logic          addr_ok;

  always_ff @(posedge clk) begin
    if (!xreset) begin
      rx_s1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_q  <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rx_s  <= rx_s1;
      rx_q  <= rx_s;
    end
  end

  // Fires once, on the cycle the low run reaches BRK_N; saturation
  // keeps a long break from re-triggering.
  assign brk_hit = !rx_s && (brk_cnt == BRK_M1);

  always_ff @(posedge clk) begin
    if (!xreset) begin
      brk_cnt <= '0;
    end else if (rx_s) begin
      brk_cnt <= '0;
    end else if (brk_cnt != BRK_TOP) begin
      brk_cnt <= brk_cnt + 1'b1;
    end
  end

  // rx_bit: 0 = start, 1..8 = data, 9 = stop.
  always_ff @(posedge clk) begin
    if (!xreset) begin
      rx_on      <= 1'b0;
      rx_cnt     <= '0;
      rx_bit     <= 4'd0;
      rx_sh      <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == ST_BRK) begin
        rx_on <= 1'b0;
      end else if (!rx_on) begin
        if (rx_q && !rx_s) begin
          rx_on  <= 1'b1;
          rx_cnt <= '0;
          rx_bit <= 4'd0;
        end
      end else if (rx_cnt == ((rx_bit == 4'd0) ? HALF_M1 : DIV_M1)) begin
        rx_cnt <= '0;
        if (rx_bit == 4'd0) begin
          if (rx_s) rx_on <= 1'b0;
          else rx_bit <= 4'd1;
        end else if (rx_bit == 4'd9) begin
          rx_on      <= 1'b0;
          byte_valid <= rx_s;
          frame_err  <= !rx_s;
        end else begin
          rx_sh  <= {rx_s, rx_sh[7:1]};
          rx_bit <= rx_bit + 4'd1;
        end
      end else begin
        rx_cnt <= rx_cnt + 1'b1;
      end
    end
  end

  assign len_nxt = {rx_sh, len[31:8]};
  assign addr_ok = (addr >> ADDR_BITS) == 32'd0;

  always_ff @(posedge clk) begin
    if (!xreset) begin
      state       <= ST_IDLE;
      hdr_idx     <= 2'd0;
      addr        <= 32'd0;
      len         <= 32'd0;
      core_xreset <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      m.m_adr     <= 32'd0;
      m.m_dw      <= 32'd0;
      m.m_we      <= 4'd0;
    end else begin
      m.m_we <= 4'd0;
      if (brk_hit) begin
        state       <= ST_BRK;
        core_xreset <= 1'b0;
        busy        <= 1'b1;
        err         <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: core_xreset <= 1'b1;
          ST_BRK: if (rx_s) state <= ST_SYNC;
          ST_SYNC: begin
            hdr_idx <= 2'd0;
            if (frame_err) state <= ST_ERR;
            else if (byte_valid)
              state <= (rx_sh == 8'hA5) ? ST_ADR : ST_ERR;
          end
          ST_ADR: begin
            if (frame_err) begin
              state <= ST_ERR;
            end else if (byte_valid) begin
              addr    <= {rx_sh, addr[31:8]};
              hdr_idx <= hdr_idx + 2'd1;
              if (hdr_idx == 2'd3) state <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (frame_err) begin
              state <= ST_ERR;
            end else if (byte_valid) begin
              len     <= len_nxt;
              hdr_idx <= hdr_idx + 2'd1;
              if (hdr_idx == 2'd3)
                state <= (len_nxt == 32'd0) ? ST_DONE : ST_DATA;
            end
          end
          ST_DATA: begin
            if (frame_err) begin
              state <= ST_ERR;
            end else if (byte_valid) begin
              if (addr_ok) begin
                m.m_we  <= 4'b0001 << addr[1:0];
                m.m_adr <= {addr[31:2], 2'b00};
                m.m_dw  <= {4{rx_sh}};
              end else begin
                err <= 1'b1;
              end
              addr <= addr + 32'd1;
              len  <= len - 32'd1;
              if (len == 32'd1) state <= ST_DONE;
            end
          end
          ST_DONE: begin
            busy        <= 1'b0;
            core_xreset <= 1'b1;
            state       <= ST_IDLE;
          end
          ST_ERR: begin
            err  <= 1'b1;
            busy <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rv_uart_loader.sv
// tb_rv_uart_loader: directed bench for the serial loader at DIV=16.
// Drives rxd frames and breaks, logs port-B writes, checks against fixed vectors.
module tb_rv_uart_loader;

  logic clk;
  logic xreset;
  logic rxd;
  logic core_xreset;
  logic busy;
  logic err;

  rv_uart_loader_if m_if ();

  rv_uart_loader #(
    .CLK_HZ(1600),
    .BAUD(100),
    .ADDR_BITS(17),
    .BREAK_BITS(20)
  ) dut (
    .clk(clk),
    .xreset(xreset),
    .rxd(rxd),
    .core_xreset(core_xreset),
    .busy(busy),
    .err(err),
    .m(m_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int nw = 0;
  int rst_we = 0;
  logic [31:0] w_adr [32];
  logic [3:0]  w_we  [32];
  logic [31:0] w_dw  [32];

  always @(posedge clk) begin
    #1;
    if (m_if.m_we != 4'd0 && nw < 32) begin
      w_adr[nw] = m_if.m_adr;
      w_we[nw]  = m_if.m_we;
      w_dw[nw]  = m_if.m_dw;
      nw = nw + 1;
    end
    if (!xreset && (m_if.m_we != 4'd0 || busy)) rst_we = rst_we + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(16);
    end
    rxd = stop;
    tick(16);
    rxd = 1'b1;
    tick(4);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic send_break(input int n);
    rxd = 1'b0;
    tick(n);
    rxd = 1'b1;
    tick(24);
  endtask

  task automatic check_wr(input string tag, input int i, input logic [31:0] a,
                          input logic [3:0] we, input logic [31:0] dw);
    check({tag, "_adr"}, w_adr[i], a);
    check({tag, "_we"}, {28'd0, w_we[i]}, {28'd0, we});
    check({tag, "_dw"}, w_dw[i], dw);
  endtask

  initial begin
    xreset = 1'b0;
    rxd = 1'b1;

    // 1: reset values and one-cycle release latency
    tick(4);
    check("rst_core", core_xreset, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_we", {28'd0, m_if.m_we}, 32'd0);
    check("rst_err", err, 1'b0);
    check("rst_adr", m_if.m_adr, 32'd0);
    check("rst_dw", m_if.m_dw, 32'd0);
    xreset = 1'b1;
    tick(1);
    check("rel_core", core_xreset, 1'b1);
    check("rel_busy", busy, 1'b0);
    tick(20);
    check("t1_nw", nw, 0);
    check("t1_rst_activity", rst_we, 0);

    // 2: normal load of five bytes at 0x10
    send_break(320);
    check("t2_busy", busy, 1'b1);
    check("t2_core", core_xreset, 1'b0);
    send_byte(8'hA5, 1'b1);
    send_word(32'h0000_0010);
    send_word(32'd5);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    tick(8);
    check("t2_nw", nw, 5);
    check_wr("t2_w0", 0, 32'h10, 4'b0001, 32'h1111_1111);
    check_wr("t2_w1", 1, 32'h10, 4'b0010, 32'h2222_2222);
    check_wr("t2_w2", 2, 32'h10, 4'b0100, 32'h3333_3333);
    check_wr("t2_w3", 3, 32'h10, 4'b1000, 32'h4444_4444);
    check_wr("t2_w4", 4, 32'h14, 4'b0001, 32'h5555_5555);
    check("t2_end_busy", busy, 1'b0);
    check("t2_end_core", core_xreset, 1'b1);
    check("t2_end_err", err, 1'b0);
    check("t2_end_we", {28'd0, m_if.m_we}, 32'd0);
    check("t2_hold_adr", m_if.m_adr, 32'h14);

    // 3: one cycle short of a break
    send_break(319);
    tick(200);
    check("t3_core", core_xreset, 1'b1);
    check("t3_busy", busy, 1'b0);
    check("t3_nw", nw, 5);

    // 4: bad sync, then recovery with a zero-length load
    send_break(320);
    send_byte(8'h5A, 1'b1);
    tick(4);
    check("t4_err", err, 1'b1);
    check("t4_core", core_xreset, 1'b0);
    check("t4_busy", busy, 1'b0);
    send_break(320);
    check("t4_brk_err", err, 1'b0);
    check("t4_brk_busy", busy, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_word(32'h0000_0100);
    send_word(32'd0);
    tick(8);
    check("t4_done_err", err, 1'b0);
    check("t4_done_core", core_xreset, 1'b1);
    check("t4_done_busy", busy, 1'b0);
    check("t4_nw", nw, 5);

    // 5: load running past the top of RAM
    send_break(320);
    send_byte(8'hA5, 1'b1);
    send_word(32'h0001_FFFE);
    send_word(32'd4);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    check("t5_err_in", err, 1'b0);
    send_byte(8'hCC, 1'b1);
    check("t5_err_out", err, 1'b1);
    check("t5_core_mid", core_xreset, 1'b0);
    send_byte(8'hDD, 1'b1);
    tick(8);
    check("t5_nw", nw, 7);
    check_wr("t5_w0", 5, 32'h1_FFFC, 4'b0100, 32'hAAAA_AAAA);
    check_wr("t5_w1", 6, 32'h1_FFFC, 4'b1000, 32'hBBBB_BBBB);
    check("t5_core", core_xreset, 1'b1);
    check("t5_busy", busy, 1'b0);
    check("t5_err_end", err, 1'b1);

    // 6a: framing error inside DATA
    send_break(320);
    send_byte(8'hA5, 1'b1);
    send_word(32'h0000_0100);
    send_word(32'd3);
    send_byte(8'h66, 1'b1);
    send_byte(8'h77, 1'b0);
    tick(4);
    check("t6a_nw", nw, 8);
    check_wr("t6a_w0", 7, 32'h100, 4'b0001, 32'h6666_6666);
    check("t6a_err", err, 1'b1);
    check("t6a_core", core_xreset, 1'b0);
    check("t6a_busy", busy, 1'b0);

    // 6b: reset pulse in the middle of a DATA byte
    send_break(320);
    send_byte(8'hA5, 1'b1);
    send_word(32'h0000_0201);
    send_word(32'd3);
    send_byte(8'h99, 1'b1);
    check("t6b_nw", nw, 9);
    check_wr("t6b_w0", 8, 32'h200, 4'b0010, 32'h9999_9999);
    rxd = 1'b0;
    tick(40);
    xreset = 1'b0;
    tick(1);
    check("t6b_core", core_xreset, 1'b0);
    check("t6b_busy", busy, 1'b0);
    check("t6b_we", {28'd0, m_if.m_we}, 32'd0);
    check("t6b_adr", m_if.m_adr, 32'd0);
    check("t6b_dw", m_if.m_dw, 32'd0);
    check("t6b_err", err, 1'b0);
    rxd = 1'b1;
    xreset = 1'b1;
    tick(1);
    check("t6b_rel_core", core_xreset, 1'b1);
    tick(200);
    check("t6b_end_nw", nw, 9);
    check("t6b_end_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
